mac_sequencer: RTL

- Initiator-side controller for the signed multiply-accumulate unit (`mac`). It drives the MAC's `a`, `b`, `enable` and `reset` pins and reads back its quantized `out`.
- It accepts a valid/ready stream of signed operand pairs and groups them into dot products of LENGTH terms.
- It inserts the one extra flush enable the MAC needs, because MAC `out` lags `sum_reg` by one enable. It captures the quantized result, presents it on a valid/ready output, then clears the MAC for the next vector.
- It sits between the operand fetch logic and a single MAC instance inside each neuron lane.

---
 rtl/nn_pkg.sv | 16 +
 rtl/mac_sequencer.sv | 81 ++++++++
 2 files changed

// File: rtl/nn_pkg.sv
// Shared neuron-lane definitions: default datapath sizes and the
// state encodings of the MAC sequencer.
package nn_pkg;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_LENGTH = 3;

    typedef enum logic [2:0] {
        ST_CLEAR   = 3'd0,
        ST_ACCUM   = 3'd1,
        ST_FLUSH   = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_OUTPUT  = 3'd4
    } state_t;

endpackage

// File: rtl/mac_sequencer.sv
// Drives one MAC through LENGTH-term dot products: accumulate, flush,
// capture the quantized result, then clear the MAC for the next vector.
module mac_sequencer
    import nn_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int LENGTH = DEF_LENGTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH-1:0] mac_a,
    output logic [WIDTH-1:0] mac_b,
    output logic             mac_enable,
    output logic             mac_reset,
    input  logic [WIDTH-1:0] mac_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    localparam int CW = $clog2(LENGTH + 1);
    localparam logic [CW-1:0] LAST = CW'(LENGTH - 1);

    state_t        state;
    logic [CW-1:0] count;
    logic          accept;

    // Operands pass straight through so the MAC samples on the handshake edge.
    assign in_ready   = (state == ST_ACCUM);
    assign accept     = in_valid && in_ready;
    assign mac_enable = accept || (state == ST_FLUSH);
    assign mac_a      = in_ready ? in_a : '0;
    assign mac_b      = in_ready ? in_b : '0;
    assign busy       = !((state == ST_ACCUM) && (count == '0));

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_CLEAR;
            count     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            mac_reset <= 1'b1;
        end else begin
            mac_reset <= 1'b0;
            unique case (state)
                ST_CLEAR: state <= ST_ACCUM;
                ST_ACCUM: begin
                    if (accept) begin
                        if (count == LAST) begin
                            count <= '0;
                            state <= ST_FLUSH;
                        end else begin
                            count <= count + CW'(1);
                        end
                    end
                end
                ST_FLUSH: state <= ST_CAPTURE;
                // MAC clears asynchronously, so reset rises only after capture.
                ST_CAPTURE: begin
                    out_data  <= mac_out;
                    out_valid <= 1'b1;
                    mac_reset <= 1'b1;
                    state     <= ST_OUTPUT;
                end
                ST_OUTPUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_ACCUM;
                    end
                end
                default: state <= ST_CLEAR;
            endcase
        end
    end

endmodule
